// File: rtl/rr_pkg.sv
// Shared types and default sizing for the round-robin burst transfer controller.
package rr_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int LW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/onehot_enc.sv
// One-hot to index encoder; ok_o flags an input with exactly one bit set.
module onehot_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          nz_o,
  output logic          ok_o
);
  // OR of set-bit indices: exact whenever the input really is one-hot
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (vec_i[i]) idx_o = idx_o | IW'(i);
  end

  assign nz_o = |vec_i;
  assign ok_o = nz_o && ((vec_i & (vec_i - N'(1))) == '0);
endmodule

// File: rtl/rr_xfer_ctrl.sv
// Locks onto the requester granted by the upstream arbiter and streams its
// burst (len+1 beats) to the sink, with abort on request drop.
module rr_xfer_ctrl
  import rr_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int LW   = LW_DEF,
  localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  grant,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic [NREQ*LW-1:0] len_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    out_src,
  output logic             out_last,
  output logic [NREQ-1:0]  ack,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             grant_err
);
  state_e        state_q, state_d;
  logic [SW-1:0] src_q, src_d;
  logic [LW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0][DW-1:0] data_arr;
  logic [NREQ-1:0][LW-1:0] len_arr;
  assign data_arr = data_in;
  assign len_arr  = len_in;

  logic [SW-1:0] g_idx;
  logic          g_nz, g_ok;

  onehot_enc #(.N(NREQ), .IW(SW)) u_gdec (
    .vec_i (grant),
    .idx_o (g_idx),
    .nz_o  (g_nz),
    .ok_o  (g_ok)
  );

  logic req_src, in_burst, beat;
  assign req_src  = req[src_q];
  assign in_burst = (state_q == LOCK) || (state_q == XFER);

  // Outputs are gated by rst so they read zero during the reset cycle itself
  assign abort     = !rst && in_burst && !req_src;
  assign out_valid = !rst && (state_q == XFER) && req_src;
  assign beat      = out_valid && out_ready;
  assign out_last  = out_valid && (cnt_q == '0);
  assign out_data  = out_valid ? data_arr[src_q] : '0;
  assign out_src   = out_valid ? src_q : '0;
  assign busy      = !rst && (state_q != IDLE);
  assign done      = !rst && (state_q == DONE);
  assign grant_err = !rst && (state_q == IDLE) && g_nz && !g_ok;

  for (genvar i = 0; i < NREQ; i++) begin : g_ack
    assign ack[i] = beat && (src_q == SW'(i));
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (g_ok && req[g_idx]) begin
        state_d = LOCK;
        src_d   = g_idx;
        cnt_d   = len_arr[g_idx];
      end
      LOCK: state_d = req_src ? XFER : IDLE;
      XFER: begin
        if (!req_src)              state_d = IDLE;
        else if (beat && cnt_q == '0) state_d = DONE;
        else if (beat)             cnt_d   = cnt_q - LW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rr_xfer_ctrl.sv
// Random and directed stimulus for rr_xfer_ctrl, checked every cycle against
// a burst-level reference model (phase + beats remaining).
module tb_rr_xfer_ctrl;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int LW   = 4;
  localparam int SW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, grant;
  logic [NREQ*DW-1:0]   data_in;
  logic [NREQ*LW-1:0]   len_in;
  logic                 out_ready;
  logic                 out_valid, out_last, busy, done, abort, grant_err;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_src;
  logic [NREQ-1:0]      ack;

  rr_xfer_ctrl #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .data_in(data_in),
    .len_in(len_in), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_last(out_last), .ack(ack),
    .busy(busy), .done(done), .abort(abort), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=lock 2=transfer 3=done; left = beats still owed
  int m_phase = 0, m_src = 0, m_left = 0;
  int beats_seen, first_valid_cyc, cyc;

  function automatic int dat(input int i);
    return int'((data_in >> (i*DW)) & 8'hff);
  endfunction
  function automatic int lenf(input int i);
    return int'((len_in >> (i*LW)) & 4'hf);
  endfunction

  // Inputs are already driven; check at the falling edge, then advance model.
  task automatic step();
    int e_valid, e_data, e_src, e_last, e_ack, e_busy, e_done, e_abort, e_gerr;
    bit rq;
    #4;
    rq = req[m_src];
    e_valid = (!rst && m_phase == 2 && rq) ? 1 : 0;
    e_data  = e_valid ? dat(m_src) : 0;
    e_src   = e_valid ? m_src : 0;
    e_last  = (e_valid && m_left == 1) ? 1 : 0;
    e_ack   = (e_valid && out_ready) ? (1 << m_src) : 0;
    e_busy  = (!rst && m_phase != 0) ? 1 : 0;
    e_done  = (!rst && m_phase == 3) ? 1 : 0;
    e_abort = (!rst && (m_phase == 1 || m_phase == 2) && !rq) ? 1 : 0;
    e_gerr  = (!rst && m_phase == 0 && grant != 0 && $countones(grant) != 1) ? 1 : 0;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_data",  32'(out_data),  32'(e_data));
    chk("out_src",   32'(out_src),   32'(e_src));
    chk("out_last",  32'(out_last),  32'(e_last));
    chk("ack",       32'(ack),       32'(e_ack));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    chk("abort",     32'(abort),     32'(e_abort));
    chk("grant_err", 32'(grant_err), 32'(e_gerr));
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (ack != 0) beats_seen++;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_src = 0; m_left = 0;
    end else begin
      case (m_phase)
        0: if ($countones(grant) == 1) begin
             int k = 0;
             for (int i = 0; i < NREQ; i++) if (grant[i]) k = i;
             if (req[k]) begin m_phase = 1; m_src = k; m_left = lenf(k) + 1; end
           end
        1: m_phase = rq ? 2 : 0;
        2: if (!rq) m_phase = 0;
           else if (out_ready) begin
             if (m_left == 1) m_phase = 3; else m_left--;
           end
        default: m_phase = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    rst = 0; req = '0; grant = '0; out_ready = 1'b1;
    data_in = 32'h44_33_22_11; len_in = 16'h3_2_1_0;
  endtask

  // Standard burst on requester 2 with len 2 (3 beats)
  task automatic start_burst2();
    req = 4'b0100; grant = 4'b0100; len_in = 16'h0_2_0_0;
    beats_seen = 0; first_valid_cyc = -1;
    cyc = 0;
    step();
    grant = '0;
  endtask

  initial begin
    idle_in();
    rst = 1; req = 4'hf; grant = 4'b0110;
    step(); step();
    idle_in();
    step();

    // Basic 3-beat burst and 2-cycle grant-to-valid latency
    start_burst2();
    repeat (6) step();
    chk("lat_first_valid", 32'(first_valid_cyc), 32'd2);
    chk("beats_basic", 32'(beats_seen), 32'd3);

    // Stall mid-burst for three cycles
    start_burst2();
    step(); step();
    out_ready = 0; repeat (3) step();
    out_ready = 1; repeat (5) step();
    chk("beats_stall", 32'(beats_seen), 32'd3);

    // Requester drops after first beat
    start_burst2();
    step(); step();
    req = '0; step();
    repeat (3) step();
    chk("beats_abort", 32'(beats_seen), 32'd1);

    // Non-one-hot grant
    idle_in(); req = 4'b0110; grant = 4'b0110;
    step(); step();
    idle_in(); step();

    // Reset during second beat
    start_burst2();
    step(); step();
    rst = 1; step();
    rst = 0; repeat (3) step();
    chk("beats_rst", 32'(beats_seen), 32'd1);

    // Grant moves mid-burst; locked transfer unaffected
    idle_in(); start_burst2();
    req = 4'b0101; grant = 4'b0001;
    repeat (6) step();
    chk("beats_gmove", 32'(beats_seen), 32'd3);
    grant = '0; req = '0; repeat (2) step();

    // Random traffic
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(31) == 0) req[i] = ~req[i];
      r = $urandom_range(99);
      if (r < 45)      grant = '0;
      else if (r < 85) grant = NREQ'(1 << $urandom_range(NREQ-1));
      else             grant = NREQ'($urandom);
      data_in   = $urandom;
      len_in    = NREQ*LW'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
